disp_select: RTL

DISP_SELECT -- requirements
Module: disp_select

---
 rtl/disp_select.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/disp_select.sv
// disp_select: picks the minimum-SSD disparity out of N_CAND candidates.
// For each window, SSD = f2sum + g2_sum - 2*fg_sum is computed per candidate.
// The result is the lowest SSD and its index; on a tie the earlier index wins.
// Pipeline:
//   p0 - registers the accepted candidate operands and its index.
//   p1 - registers the saturated SSD.
//   p2 - compares against the running minimum (best_ssd / best_idx).
// Optional build macro DISPSEL_THRESH_EN: when defined, result_ok reports
// best_ssd <= THRESH; otherwise result_ok is simply 1 with every result.
module disp_select #(
    parameter int          N_CAND = 64,
    parameter logic [15:0] THRESH = 16'd2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] f2sum,
    input  logic        cand_valid,
    input  logic [13:0] fg_sum,
    input  logic [13:0] g2_sum,
    output logic        cand_ready,
    output logic        busy,
    output logic [5:0]  best_idx,
    output logic [15:0] best_ssd,
    output logic        result_valid,
    output logic        result_ok
);

    localparam logic [5:0] LAST_IDX = 6'(N_CAND - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    logic [5:0]  cand_cnt;
    logic        drain_cnt;

    logic [13:0] f2_lat;

    logic [13:0] fg_p0;
    logic [13:0] g2_p0;
    logic [5:0]  idx_p0;
    logic        vld_p0;

    logic [15:0] ssd_p1;
    logic [5:0]  idx_p1;
    logic        vld_p1;

    logic               accept;
    logic signed [16:0] ssd_raw;
    logic               upd;
    logic [15:0]        min_next;
    logic               ok_next;

    // Full-precision SSD. The 17-bit signed range covers -32766..+32766.
    function automatic logic signed [16:0] calc_ssd(
        input logic [13:0] f2,
        input logic [13:0] g2,
        input logic [13:0] fg
    );
        logic signed [16:0] a;
        logic signed [16:0] b;
        logic signed [16:0] c;
        a = signed'({3'b000, f2});
        b = signed'({3'b000, g2});
        c = signed'({2'b00, fg, 1'b0});
        return a + b - c;
    endfunction

    // Negative values clamp to 0. The top is capped at 16'hFFFE, so any real
    // candidate always beats the 16'hFFFF "no match yet" sentinel.
    function automatic logic [15:0] sat_ssd(input logic signed [16:0] x);
        if (x < 17'sd0) begin
            return 16'h0000;
        end else if (x > 17'sd65534) begin
            return 16'hFFFE;
        end else begin
            return x[15:0];
        end
    endfunction

    // A start pulse has priority: a candidate offered in the same cycle is dropped.
    assign accept  = cand_valid && cand_ready && !start;
    assign ssd_raw = calc_ssd(f2_lat, g2_p0, fg_p0);

    assign upd      = vld_p1 && (ssd_p1 < best_ssd);
    assign min_next = upd ? ssd_p1 : best_ssd;

`ifdef DISPSEL_THRESH_EN
    assign ok_next = (min_next <= THRESH);
`else
    assign ok_next = 1'b1;
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
`endif

    // Window control FSM. All outputs are registered.
    // A start pulse from any state (re)enters LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cand_ready   <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_ok    <= 1'b0;
            cand_cnt     <= 6'd0;
            drain_cnt    <= 1'b0;
        end else if (start) begin
            state        <= LOAD;
            busy         <= 1'b1;
            cand_ready   <= 1'b0;
            result_valid <= 1'b0;
            result_ok    <= 1'b0;
            cand_cnt     <= 6'd0;
            drain_cnt    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            result_ok    <= 1'b0;
            case (state)
                IDLE: begin
                    busy       <= 1'b0;
                    cand_ready <= 1'b0;
                end
                LOAD: begin
                    state      <= RUN;
                    cand_ready <= 1'b1;
                end
                RUN: begin
                    if (accept) begin
                        if (cand_cnt == LAST_IDX) begin
                            state      <= DRAIN;
                            cand_ready <= 1'b0;
                            drain_cnt  <= 1'b0;
                        end else begin
                            cand_cnt <= cand_cnt + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles let the final candidate clear p1 and p2.
                    if (drain_cnt) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        result_ok    <= ok_next;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cand_ready <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline valids. A start flushes any in-flight candidate of the old window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0 && !start;
        end
    end

    // Datapath registers: window f2 latch, p0 operand capture, p1 SSD.
    always_ff @(posedge clk) begin
        if (start) begin
            f2_lat <= f2sum;
        end
        // ---- stage p0: accepted candidate operands ----
        if (accept) begin
            fg_p0  <= fg_sum;
            g2_p0  <= g2_sum;
            idx_p0 <= cand_cnt;
        end
        // ---- stage p1: saturated SSD ----
        if (vld_p0) begin
            ssd_p1 <= sat_ssd(ssd_raw);
            idx_p1 <= idx_p0;
        end
    end

    // ---- stage p2: running minimum. Strict compare keeps the earlier index on ties ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_ssd <= 16'hFFFF;
            best_idx <= 6'd0;
        end else if (start) begin
            best_ssd <= 16'hFFFF;
            best_idx <= 6'd0;
        end else if (upd) begin
            best_ssd <= min_next;
            best_idx <= idx_p1;
        end
    end

endmodule
